// File: rtl/year_leap_tracker.sv
// year_leap_tracker: calendar year register with Gregorian leap flag and host load via subtract-divide FSM
module year_leap_tracker #(
  parameter int YEAR_W     = 14,
  parameter int MAX_YEAR   = 9999,
  parameter int RESET_YEAR = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              year_tick,
  input  logic              load_valid,
  input  logic [YEAR_W-1:0] load_year,
  output logic              load_ready,
  output logic [YEAR_W-1:0] year,
  output logic              leap,
  output logic              busy,
  output logic              load_done
);
  typedef enum logic [1:0] {IDLE, DIV400, DIV100, COMMIT} state_t;
  localparam logic [YEAR_W-1:0] MAX_Y = YEAR_W'(MAX_YEAR);
  localparam logic [YEAR_W-1:0] RST_Y = YEAR_W'(RESET_YEAR);
  localparam logic [YEAR_W-1:0] C400 = YEAR_W'(400);
  localparam logic [YEAR_W-1:0] C100 = YEAR_W'(100);
  localparam logic [8:0] RST_400 = 9'(RESET_YEAR % 400);
  localparam logic [6:0] RST_100 = 7'(RESET_YEAR % 100);
  state_t state, state_n;
  logic [8:0] r400, tmp400;
  logic [6:0] r100;
  logic [YEAR_W-1:0] work, ld, clamp;
  logic pend, inc;
  assign clamp = load_year > MAX_Y ? MAX_Y : load_year;
  assign inc = year_tick | pend;
  assign load_ready = state == IDLE;
  assign busy = !load_ready;
  assign leap = r400 == 9'd0 || (r100 != 7'd0 && r400[1:0] == 2'd0);
  // state register; reset aborts any load in progress
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: accept in IDLE, subtract 400s, then 100s, then commit
  always_comb begin
    state_n = state;
    state_n = state == IDLE   ? (load_valid ? DIV400 : IDLE) :
              state == DIV400 ? (work >= C400 ? DIV400 : DIV100) :
              state == DIV100 ? (work >= C100 ? DIV100 : COMMIT) : IDLE;
  end
  // year/residue datapath; ticks seen while busy are held in pend and applied in IDLE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      year <= RST_Y;
      r400 <= RST_400;
      r100 <= RST_100;
      work <= '0;
      ld <= '0;
      tmp400 <= '0;
      pend <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= state == COMMIT;
      pend <= state == IDLE ? 1'b0 : pend | year_tick;
      if (state == IDLE) begin
        if (inc) begin
          year <= year == MAX_Y ? '0 : year + 1'b1;
          r400 <= r400 == 9'd399 ? 9'd0 : r400 + 9'd1;
          r100 <= r100 == 7'd99 ? 7'd0 : r100 + 7'd1;
        end
        if (load_valid) begin
          work <= clamp;
          ld <= clamp;
        end
      end else if (state == DIV400) begin
        if (work >= C400) work <= work - C400;
        else tmp400 <= work[8:0];
      end else if (state == DIV100) begin
        if (work >= C100) work <= work - C100;
      end else begin
        year <= ld;
        r400 <= tmp400;
        r100 <= work[6:0];
      end
    end
endmodule

// File: tb/tb_year_leap_tracker.sv
// tb_year_leap_tracker: directed and randomized checks of year_leap_tracker against an arithmetic calendar model
module tb_year_leap_tracker;
  logic clk, rst, year_tick, load_valid, load_ready, leap, busy, load_done;
  logic [13:0] load_year, year;
  int checks = 0, passes = 0, exp_year = 2000;

  year_leap_tracker dut (
    .clk(clk), .rst(rst), .year_tick(year_tick), .load_valid(load_valid),
    .load_year(load_year), .load_ready(load_ready), .year(year), .leap(leap),
    .busy(busy), .load_done(load_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic bit leap_of(input int y);
    return (y % 4 == 0 && y % 100 != 0) || y % 400 == 0;
  endfunction

  function automatic int lat_of(input int c);
    return c / 400 + 1 + (c % 400) / 100 + 1 + 1;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    year_tick = 1;
    step();
    year_tick = 0;
    exp_year = (exp_year + 1) % 10000;
    chk("tick_year", int'(year), exp_year);
    chk("tick_leap", int'(leap), int'(leap_of(exp_year)));
  endtask

  task automatic do_load(input int y, input bit inj);
    int c, n;
    c = y > 9999 ? 9999 : y;
    n = 0;
    while (!load_ready && n < 64) begin step(); n++; end
    chk("ready_wait", int'(load_ready), 1);
    load_valid = 1;
    load_year = 14'(y);
    step();
    load_valid = 0;
    chk("busy_hi", int'(busy), 1);
    chk("ready_lo", int'(load_ready), 0);
    if (inj) year_tick = 1;
    n = 0;
    do begin step(); year_tick = 0; n++; end while (!load_done && n < 64);
    chk("latency", n, lat_of(c));
    chk("load_year", int'(year), c);
    chk("load_leap", int'(leap), int'(leap_of(c)));
    chk("ready_hi", int'(load_ready), 1);
    chk("busy_lo", int'(busy), 0);
    exp_year = inj ? (c + 1) % 10000 : c;
    step();
    chk("done_pulse", int'(load_done), 0);
    chk("post_year", int'(year), exp_year);
    chk("post_leap", int'(leap), int'(leap_of(exp_year)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m;
    rst = 1; year_tick = 0; load_valid = 0; load_year = '0;
    step(); step();
    rst = 0;
    chk("rst_year", int'(year), 2000);
    chk("rst_leap", int'(leap), 1);
    chk("rst_ready", int'(load_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(load_done), 0);
    tick(); step(); tick(); tick();
    chk("y2003_leap", int'(leap), 0);
    tick();
    chk("y2004_leap", int'(leap), 1);
    do_load(2099, 0); tick();
    chk("y2100_leap", int'(leap), 0);
    do_load(2399, 0); tick();
    chk("y2400_leap", int'(leap), 1);
    do_load(9999, 0); tick();
    chk("wrap_year", int'(year), 0);
    chk("wrap_r400", int'(dut.r400), 0);
    do_load(12000, 0);
    do_load(2024, 1);
    // second request held while busy is ignored until ready, then accepted
    load_valid = 1; load_year = 14'd2024;
    step();
    load_year = 14'd1500;
    n = 0;
    do begin step(); n++; end while (!load_done && n < 64);
    chk("held_lat", n, 8);
    chk("held_year", int'(year), 2024);
    step();
    load_valid = 0;
    chk("held_accept", int'(busy), 1);
    m = 0;
    do begin step(); m++; end while (!load_done && m < 64);
    chk("second_lat", m, lat_of(1500));
    chk("second_year", int'(year), 1500);
    chk("second_leap", int'(leap), 0);
    // reset in the middle of a 3000 load
    load_valid = 1; load_year = 14'd3000;
    step();
    load_valid = 0;
    step();
    rst = 1;
    #1;
    chk("abort_year", int'(year), 2000);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(load_done), 0);
    step();
    rst = 0;
    exp_year = 2000;
    m = 0;
    for (int i = 0; i < 40; i++) begin step(); m += int'(load_done); end
    chk("abort_no_done", m, 0);
    chk("abort_hold", int'(year), 2000);
    load_valid = 1; load_year = 14'd123;
    step();
    load_valid = 0;
    chk("abort_accept", int'(busy), 1);
    n = 0;
    do begin step(); n++; end while (!load_done && n < 64);
    chk("abort_reload", int'(year), 123);
    exp_year = 123;
    step();
    for (int i = 0; i < 25; i++) begin
      do_load(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
      for (int k = int'($urandom_range(0, 3)); k > 0; k--) tick();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
